ft245_fifo_responder: RTL and testbench
=======================================

Name: ft245_fifo_responder

Overview:
- Synthesizable device-side model of the FT245-style asynchronous 8-bit FIFO chip. It is the responder to the FPGA-side FIFO master.
- Drives RXF#/TXE#, answers RD# by driving the data bus, and captures bytes on WR#.
- Host side has two byte FIFOs: Down (host->master, read via RD#) and Up (master->host, written via WR#).
- Used for on-chip loopback and board bring-up without the USB chip.

Parameters:
- pDepth, 16, entries per Down/Up FIFO; must be a power of 2, >=2.
- pRxfPrechargeClks, 2, clocks RXF# stays high after a read completes (1..15).
- pTxePrechargeClks, 2, clocks TXE# stays high after a write completes (1..15).

Ports:
- iClk  in  1  system clock, same domain as the master.
- iRst  in  1  reset.
- iRd_n  in  1  master read strobe, active-low.
- iWr_n  in  1  master write strobe, active-low.
- ioFifoData  inout  8  shared data bus.
- oRxF_n  out  1  low = Down byte available to read.
- oTxE_n  out  1  low = Up FIFO can accept a byte.
- iDownData  in  8  host byte to send to the master.
- iDownValid  in  1  push request for iDownData.
- oDownReady  out  1  Down FIFO not full.
- oUpData  out  8  head byte of the Up FIFO.
- oUpValid  out  1  Up FIFO not empty.
- iUpReady  in  1  host pops the Up head.
- oDownLevel  out  $clog2(pDepth)+1  Down occupancy.
- oUpLevel  out  $clog2(pDepth)+1  Up occupancy.
- oProtoErr  out  1  sticky protocol-violation flag.

Behaviour:
- Reset iRst, synchronous, active-high; clock iClk.
- Reset values:
  - oRxF_n=1, oTxE_n=1, bus Z.
  - Both FIFOs empty; levels=0, oUpValid=0, oDownReady=1, oProtoErr=0.
  - Both FSMs enter PRECHARGE with full counts.
- iRd_n, iWr_n and ioFifoData pass through 2-flop synchronizers (s0, s1). Edge detection uses s1 against the previous s1.
- Bus drive is combinational from the raw pin, as in the real chip. ioFifoData = rRdByte when (iRd_n==0 && read FSM in R_ARMED or R_ACTIVE), else Z.
- Read FSM states:
  - R_IDLE: Down empty.
  - R_ARMED: rRdByte loaded with the Down head.
  - R_ACTIVE
  - R_PRECHARGE
- Read FSM transitions:
  - R_IDLE->R_ARMED when Down is non-empty; head is copied into rRdByte that cycle, no pop.
  - R_ARMED->R_ACTIVE on synced RD# falling edge.
  - R_ACTIVE->R_PRECHARGE on synced RD# rising edge; pop Down exactly once.
  - R_PRECHARGE counts pRxfPrechargeClks, then goes to R_ARMED if non-empty, else R_IDLE.
- oRxF_n = !(state==R_ARMED) OR !iRd_n OR !s0 OR !s1.
  - This guarantees RXF# is high within the same clock RD# falls and until the registered FSM catches up.
  - It prevents a double-read by a master that samples RXF# one clock after releasing RD#.
- Write FSM states: W_IDLE, W_ACTIVE, W_PRECHARGE.
  - Falling edge of synced WR# in W_IDLE with Up not full: push the synced data (s1 stage) and go to W_ACTIVE.
  - Synced rising edge -> W_PRECHARGE for pTxePrechargeClks -> W_IDLE.
- oTxE_n = !(W_IDLE && Up not full) OR !iWr_n OR !s0 OR !s1.
- Host pushes/pops are standard valid/ready, one byte per clock. A simultaneous push and pop on the same FIFO keeps the level unchanged.
- A push to a full FIFO is ignored; a pop from an empty FIFO is ignored.
- Error cases (each sets oProtoErr sticky; cleared only by iRst):
  - Synced RD# falls while in R_IDLE or R_PRECHARGE: bus stays Z, no pop.
  - Synced WR# falls while Up is full or the write FSM is not in W_IDLE: byte dropped.
  - s1 of RD# and WR# both low in the same cycle.
- Reset mid-operation: bus goes Z and RXF#/TXE# go high on the next edge. Any in-flight byte is discarded and both FIFOs are flushed.

Decomposition:
- Package ft245_pkg holds:
  - Read and write FSM state enums.
  - Synchronizer depth constant (2).
  - Data width constant (8).
- One sub-module, sync_byte_fifo: parameter pDepth, push/pop/full/empty/level, head read combinational.
- It is instantiated twice (Down, Up).

Test Plan:
1. Reset, then idle 4 clk -> oRxF_n=1, oTxE_n=0 after precharge, bus Z, oProtoErr=0, levels 0.
2. Host pushes 0x5A; master pulses RD# low 2 clk -> oRxF_n falls, bus=0x5A while RD# low, Down level 1->0, RXF# high >= pRxfPrechargeClks after RD# rises.
3. Host pushes 0x01,0x02,0x03; master reads back-to-back -> bytes arrive in order, no duplicate, oRxF_n=1 after the third read.
4. Master drives 0x41 and pulses WR# 2 clk -> oUpValid=1, oUpData=0x41, oUpLevel=1; host pops -> level 0.
5. Fill Up with pDepth writes -> oTxE_n stays 1; a forced extra WR# with 0x99 is dropped, oUpLevel=pDepth, oProtoErr=1.
6. Assert iRst while RD# is low mid-read -> next edge bus Z, oRxF_n=1, levels 0, oProtoErr=0.

Source files
------------

// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245-style FIFO responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ft245_pkg;

  // Depth of the pin synchronizers (s0, s1)
  localparam int cSyncDepth = 2;

  // Width of the FT245 data bus and of every FIFO entry
  localparam int cDataWidth = 8;

  // Width of the precharge down-counters (precharge lengths 1..15)
  localparam int cPreCntWidth = 4;

  typedef enum logic [1:0] {
    R_IDLE      = 2'd0,
    R_ARMED     = 2'd1,
    R_ACTIVE    = 2'd2,
    R_PRECHARGE = 2'd3
  } rdState_t;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ACTIVE    = 2'd1,
    W_PRECHARGE = 2'd2
  } wrState_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with combinational head and occupancy count.
// Latency: a push is visible at the head on the clock after it is accepted.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_byte_fifo
  import ft245_pkg::*;
#(
  parameter int pDepth = 16
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iPush,
  input  logic [cDataWidth-1:0]   iPushData,
  input  logic                    iPop,
  output logic [cDataWidth-1:0]   oHead,
  output logic                    oFull,
  output logic                    oEmpty,
  output logic [$clog2(pDepth):0] oLevel
);

  localparam int cAw = $clog2(pDepth);
  localparam logic [cAw:0]   cFullLevel = (cAw + 1)'(pDepth);
  localparam logic [cAw:0]   cLvlOne    = (cAw + 1)'(1);
  localparam logic [cAw-1:0] cPtrOne    = cAw'(1);

  logic [cDataWidth-1:0] rMem [pDepth];
  logic [cAw-1:0]        rWrPtr;
  logic [cAw-1:0]        rRdPtr;
  logic [cAw:0]          rLevel;
  logic                  doPush;
  logic                  doPop;

  assign doPush = iPush && !oFull;
  assign doPop  = iPop && !oEmpty;

  assign oHead  = rMem[rRdPtr];
  assign oFull  = (rLevel == cFullLevel);
  assign oEmpty = (rLevel == '0);
  assign oLevel = rLevel;

  // Storage array: written only on an accepted push, no reset needed
  always_ff @(posedge iClk) begin
    if (doPush) begin
      rMem[rWrPtr] <= iPushData;
    end
  end

  // Pointers and occupancy; reset flushes the FIFO
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
      rLevel <= '0;
    end else begin
      if (doPush) begin
        rWrPtr <= rWrPtr + cPtrOne;
      end
      if (doPop) begin
        rRdPtr <= rRdPtr + cPtrOne;
      end
      case ({doPush, doPop})
        2'b10:   rLevel <= rLevel + cLvlOne;
        2'b01:   rLevel <= rLevel - cLvlOne;
        default: rLevel <= rLevel;
      endcase
    end
  end

endmodule

// File: rtl/ft245_fifo_responder.sv
// Device-side FT245 async FIFO model: RXF#/TXE# flags, RD# bus drive, WR# capture.
// Latency: strobes seen after 2-flop sync plus edge detect; bus drive is combinational on raw RD#.
// Backpressure: RXF#/TXE# throttle the master; host side uses valid/ready per byte.
module ft245_fifo_responder
  import ft245_pkg::*;
#(
  parameter int pDepth            = 16,
  parameter int pRxfPrechargeClks = 2,
  parameter int pTxePrechargeClks = 2
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iRd_n,
  input  logic                    iWr_n,
  inout  wire  [cDataWidth-1:0]   ioFifoData,
  output logic                    oRxF_n,
  output logic                    oTxE_n,
  input  logic [cDataWidth-1:0]   iDownData,
  input  logic                    iDownValid,
  output logic                    oDownReady,
  output logic [cDataWidth-1:0]   oUpData,
  output logic                    oUpValid,
  input  logic                    iUpReady,
  output logic [$clog2(pDepth):0] oDownLevel,
  output logic [$clog2(pDepth):0] oUpLevel,
  output logic                    oProtoErr
);

  localparam logic [cPreCntWidth-1:0] cRxfCnt = cPreCntWidth'(pRxfPrechargeClks);
  localparam logic [cPreCntWidth-1:0] cTxeCnt = cPreCntWidth'(pTxePrechargeClks);
  localparam logic [cPreCntWidth-1:0] cCntOne = cPreCntWidth'(1);

  // Synchronizer chains: index 0 is s0, index cSyncDepth-1 is s1
  logic [cSyncDepth-1:0]                 rRdSync;
  logic [cSyncDepth-1:0]                 rWrSync;
  logic [cSyncDepth-1:0][cDataWidth-1:0] rDataSync;
  logic                                  rRdPrev;
  logic                                  rWrPrev;

  logic                  rdS0, rdS1, wrS0, wrS1;
  logic [cDataWidth-1:0] dataS1;
  logic                  rdFall, rdRise, wrFall, wrRise;

  // FIFO interconnect
  logic                  downEmpty, downFull, downPop;
  logic [cDataWidth-1:0] downHead;
  logic                  upEmpty, upFull, upPush;

  // Read FSM
  rdState_t                rdState, rdStateNxt;
  logic [cPreCntWidth-1:0] rdCnt, rdCntNxt;
  logic                    rdLoad;
  logic                    rdErr;
  logic [cDataWidth-1:0]   rRdByte;

  // Write FSM
  wrState_t                wrState, wrStateNxt;
  logic [cPreCntWidth-1:0] wrCnt, wrCntNxt;
  logic                    wrErr;

  logic bothLow;

  assign rdS0   = rRdSync[0];
  assign rdS1   = rRdSync[cSyncDepth-1];
  assign wrS0   = rWrSync[0];
  assign wrS1   = rWrSync[cSyncDepth-1];
  assign dataS1 = rDataSync[cSyncDepth-1];

  assign rdFall = rRdPrev && !rdS1;
  assign rdRise = !rRdPrev && rdS1;
  assign wrFall = rWrPrev && !wrS1;
  assign wrRise = !rWrPrev && wrS1;

  // Strobes idle high, so synchronizers reset to 1 to avoid a phantom edge
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rRdSync   <= '1;
      rWrSync   <= '1;
      rDataSync <= '0;
      rRdPrev   <= 1'b1;
      rWrPrev   <= 1'b1;
    end else begin
      rRdSync   <= {rRdSync[cSyncDepth-2:0], iRd_n};
      rWrSync   <= {rWrSync[cSyncDepth-2:0], iWr_n};
      rDataSync <= {rDataSync[cSyncDepth-2:0], ioFifoData};
      rRdPrev   <= rdS1;
      rWrPrev   <= wrS1;
    end
  end

  sync_byte_fifo #(.pDepth(pDepth)) uDownFifo (
    .iClk      (iClk),
    .iRst      (iRst),
    .iPush     (iDownValid),
    .iPushData (iDownData),
    .iPop      (downPop),
    .oHead     (downHead),
    .oFull     (downFull),
    .oEmpty    (downEmpty),
    .oLevel    (oDownLevel)
  );

  sync_byte_fifo #(.pDepth(pDepth)) uUpFifo (
    .iClk      (iClk),
    .iRst      (iRst),
    .iPush     (upPush),
    .iPushData (dataS1),
    .iPop      (iUpReady),
    .oHead     (oUpData),
    .oFull     (upFull),
    .oEmpty    (upEmpty),
    .oLevel    (oUpLevel)
  );

  assign oDownReady = !downFull;
  assign oUpValid   = !upEmpty;

  // Read FSM state register; reset starts a full precharge
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rdState <= R_PRECHARGE;
      rdCnt   <= cRxfCnt;
    end else begin
      rdState <= rdStateNxt;
      rdCnt   <= rdCntNxt;
    end
  end

  // Read FSM next state: arm with the Down head, pop once when RD# releases
  always_comb begin
    rdStateNxt = rdState;
    rdCntNxt   = rdCnt;
    rdLoad     = 1'b0;
    downPop    = 1'b0;
    rdErr      = 1'b0;
    case (rdState)
      R_IDLE: begin
        rdErr = rdFall;
        if (!downEmpty) begin
          rdStateNxt = R_ARMED;
          rdLoad     = 1'b1;
        end
      end
      R_ARMED: begin
        if (rdFall) begin
          rdStateNxt = R_ACTIVE;
        end
      end
      R_ACTIVE: begin
        if (rdRise) begin
          rdStateNxt = R_PRECHARGE;
          rdCntNxt   = cRxfCnt;
          downPop    = 1'b1;
        end
      end
      R_PRECHARGE: begin
        rdErr = rdFall;
        if (rdCnt <= cCntOne) begin
          if (!downEmpty) begin
            rdStateNxt = R_ARMED;
            rdLoad     = 1'b1;
          end else begin
            rdStateNxt = R_IDLE;
          end
        end else begin
          rdCntNxt = rdCnt - cCntOne;
        end
      end
      default: begin
        rdStateNxt = R_PRECHARGE;
        rdCntNxt   = cRxfCnt;
      end
    endcase
  end

  // Byte presented on the bus, latched when the read FSM arms
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rRdByte <= '0;
    end else if (rdLoad) begin
      rRdByte <= downHead;
    end
  end

  // Drive follows the raw pin so data appears as soon as RD# falls
  assign ioFifoData = (!iRd_n && (rdState == R_ARMED || rdState == R_ACTIVE))
                      ? rRdByte : {cDataWidth{1'bz}};

  // Raw-pin and sync-stage terms hold RXF# high until the FSM has seen RD#
  assign oRxF_n = (rdState != R_ARMED) || !iRd_n || !rdS0 || !rdS1;

  // Write FSM state register; reset starts a full precharge
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrState <= W_PRECHARGE;
      wrCnt   <= cTxeCnt;
    end else begin
      wrState <= wrStateNxt;
      wrCnt   <= wrCntNxt;
    end
  end

  // Write FSM next state: push the synced byte on WR# fall, then precharge
  always_comb begin
    wrStateNxt = wrState;
    wrCntNxt   = wrCnt;
    upPush     = 1'b0;
    wrErr      = wrFall && ((wrState != W_IDLE) || upFull);
    case (wrState)
      W_IDLE: begin
        if (wrFall && !upFull) begin
          wrStateNxt = W_ACTIVE;
          upPush     = 1'b1;
        end
      end
      W_ACTIVE: begin
        if (wrRise) begin
          wrStateNxt = W_PRECHARGE;
          wrCntNxt   = cTxeCnt;
        end
      end
      W_PRECHARGE: begin
        if (wrCnt <= cCntOne) begin
          wrStateNxt = W_IDLE;
        end else begin
          wrCntNxt = wrCnt - cCntOne;
        end
      end
      default: begin
        wrStateNxt = W_PRECHARGE;
        wrCntNxt   = cTxeCnt;
      end
    endcase
  end

  assign oTxE_n = !((wrState == W_IDLE) && !upFull) || !iWr_n || !wrS0 || !wrS1;

  assign bothLow = !rdS1 && !wrS1;

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oProtoErr <= 1'b0;
    end else if (rdErr || wrErr || bothLow) begin
      oProtoErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Self-checking bench for ft245_fifo_responder: cycle table plus read/write sequences.
// Latency: checks sampled at the falling edge, inputs driven 1 ns after the rising edge.
// Backpressure: master tasks wait (bounded) for RXF#/TXE# before strobing.
module tb_ft245_fifo_responder;

  localparam int cDepth = 16;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iRd_n;
  logic       iWr_n;
  logic [7:0] iDownData;
  logic       iDownValid;
  logic       iUpReady;
  logic       oRxF_n;
  logic       oTxE_n;
  logic       oDownReady;
  logic [7:0] oUpData;
  logic       oUpValid;
  logic [4:0] oDownLevel;
  logic [4:0] oUpLevel;
  logic       oProtoErr;

  // Released bus reads as 0xFF through the tri1 pull
  tri1  [7:0] ioFifoData;
  logic       tbBusEn;
  logic [7:0] tbBusDrv;
  assign ioFifoData = tbBusEn ? tbBusDrv : 8'hzz;

  int nChecks = 0;
  int nFails  = 0;

  ft245_fifo_responder #(
    .pDepth            (cDepth),
    .pRxfPrechargeClks (2),
    .pTxePrechargeClks (2)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iRd_n      (iRd_n),
    .iWr_n      (iWr_n),
    .ioFifoData (ioFifoData),
    .oRxF_n     (oRxF_n),
    .oTxE_n     (oTxE_n),
    .iDownData  (iDownData),
    .iDownValid (iDownValid),
    .oDownReady (oDownReady),
    .oUpData    (oUpData),
    .oUpValid   (oUpValid),
    .iUpReady   (iUpReady),
    .oDownLevel (oDownLevel),
    .oUpLevel   (oUpLevel),
    .oProtoErr  (oProtoErr)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic       rst;
    logic       rdN;
    logic       dnVld;
    logic [7:0] dnDat;
    logic       expRxf;
    logic       expTxe;
    logic [7:0] expBus;
    logic [4:0] expDnLvl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic rdN, logic dnVld, logic [7:0] dnDat,
                              logic expRxf, logic expTxe, logic [7:0] expBus,
                              logic [4:0] expDnLvl);
    vec_t v;
    v.rst = rst; v.rdN = rdN; v.dnVld = dnVld; v.dnDat = dnDat;
    v.expRxf = expRxf; v.expTxe = expTxe; v.expBus = expBus; v.expDnLvl = expDnLvl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Wait for RXF#, pulse RD# for 2 clocks, check the byte and the RXF# hold-off
  task automatic masterRead(input logic [7:0] exp, input string tag);
    int n = 0;
    int highCnt = 0;
    while (oRxF_n !== 1'b0 && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "_rxf_ready"}, 16'(oRxF_n), 16'h0);
    iRd_n = 1'b0;
    @(negedge iClk);
    chk({tag, "_bus"}, 16'(ioFifoData), 16'(exp));
    chk({tag, "_rxf_during_rd"}, 16'(oRxF_n), 16'h1);
    tick();
    tick();
    iRd_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge iClk);
      if (oRxF_n === 1'b1) highCnt++;
      tick();
    end
    chk({tag, "_rxf_precharge"}, 16'(highCnt), 16'd4);
  endtask

  // Optionally wait for TXE#, then drive a byte and pulse WR# for 2 clocks
  task automatic masterWrite(input logic [7:0] d, input bit waitTxe, input string tag);
    int n = 0;
    if (waitTxe) begin
      while (oTxE_n !== 1'b0 && n < 64) begin
        tick();
        n++;
      end
      chk({tag, "_txe_ready"}, 16'(oTxE_n), 16'h0);
    end
    tbBusDrv = d;
    tbBusEn  = 1'b1;
    iWr_n    = 1'b0;
    @(negedge iClk);
    chk({tag, "_txe_during_wr"}, 16'(oTxE_n), 16'h1);
    tick();
    tick();
    iWr_n   = 1'b1;
    tbBusEn = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    iRst = 1'b1; iRd_n = 1'b1; iWr_n = 1'b1;
    iDownData = 8'h00; iDownValid = 1'b0; iUpReady = 1'b0;
    tbBusEn = 1'b0; tbBusDrv = 8'h00;

    // Reset, idle through precharge, then one host byte read by a 2-clock RD# pulse
    //          rst  rdN  vld  dat     rxf  txe  bus    dnLvl
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 5'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 5'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 5'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 5'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 5'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 8'hFF, 5'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 5'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 5'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 5'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 5'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 5'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 5'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 5'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 5'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 5'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 5'd0));

    repeat (3) @(posedge iClk);
    #1;

    foreach (vecs[i]) begin
      iRst       = vecs[i].rst;
      iRd_n      = vecs[i].rdN;
      iDownValid = vecs[i].dnVld;
      iDownData  = vecs[i].dnDat;
      @(negedge iClk);
      chk($sformatf("vec%0d_rxf", i), 16'(oRxF_n), 16'(vecs[i].expRxf));
      chk($sformatf("vec%0d_txe", i), 16'(oTxE_n), 16'(vecs[i].expTxe));
      chk($sformatf("vec%0d_bus", i), 16'(ioFifoData), 16'(vecs[i].expBus));
      chk($sformatf("vec%0d_dnlvl", i), 16'(oDownLevel), 16'(vecs[i].expDnLvl));
      chk($sformatf("vec%0d_dnrdy", i), 16'(oDownReady), 16'h1);
      chk($sformatf("vec%0d_uplvl", i), 16'(oUpLevel), 16'h0);
      chk($sformatf("vec%0d_err", i), 16'(oProtoErr), 16'h0);
      tick();
    end
    iDownValid = 1'b0;

    // Three host bytes read back-to-back, in order, without a duplicate
    iDownValid = 1'b1; iDownData = 8'h01; tick();
    iDownData = 8'h02; tick();
    iDownData = 8'h03; tick();
    iDownValid = 1'b0;
    @(negedge iClk);
    chk("b2b_dnlvl_loaded", 16'(oDownLevel), 16'd3);
    tick();
    masterRead(8'h01, "b2b_0");
    masterRead(8'h02, "b2b_1");
    masterRead(8'h03, "b2b_2");
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge iClk);
      if (oRxF_n === 1'b1) cnt++;
      tick();
    end
    chk("b2b_rxf_stays_high", 16'(cnt), 16'd10);
    chk("b2b_dnlvl_empty", 16'(oDownLevel), 16'd0);
    chk("b2b_err", 16'(oProtoErr), 16'h0);

    // Single master write, then host pop
    masterWrite(8'h41, 1'b1, "wr41");
    repeat (3) tick();
    @(negedge iClk);
    chk("wr41_upvalid", 16'(oUpValid), 16'h1);
    chk("wr41_updata", 16'(oUpData), 16'h41);
    chk("wr41_uplvl", 16'(oUpLevel), 16'd1);
    tick();
    iUpReady = 1'b1;
    tick();
    iUpReady = 1'b0;
    @(negedge iClk);
    chk("pop_uplvl", 16'(oUpLevel), 16'd0);
    chk("pop_upvalid", 16'(oUpValid), 16'h0);
    tick();

    // Fill the Up FIFO, then force one more write that must be dropped
    for (int i = 0; i < cDepth; i++) begin
      masterWrite(8'h10 + 8'(i), 1'b1, $sformatf("fill%0d", i));
    end
    repeat (4) tick();
    @(negedge iClk);
    chk("full_txe", 16'(oTxE_n), 16'h1);
    chk("full_uplvl", 16'(oUpLevel), 16'(cDepth));
    chk("full_err_before", 16'(oProtoErr), 16'h0);
    chk("full_head", 16'(oUpData), 16'h10);
    tick();
    masterWrite(8'h99, 1'b0, "forced");
    repeat (4) tick();
    @(negedge iClk);
    chk("forced_uplvl", 16'(oUpLevel), 16'(cDepth));
    chk("forced_err", 16'(oProtoErr), 16'h1);
    chk("forced_head", 16'(oUpData), 16'h10);
    chk("forced_txe", 16'(oTxE_n), 16'h1);
    tick();

    // Reset asserted while RD# is low mid-read
    iDownValid = 1'b1; iDownData = 8'h77; tick();
    iDownValid = 1'b0;
    cnt = 0;
    while (oRxF_n !== 1'b0 && cnt < 64) begin
      tick();
      cnt++;
    end
    chk("rstmid_rxf_ready", 16'(oRxF_n), 16'h0);
    iRd_n = 1'b0;
    @(negedge iClk);
    chk("rstmid_bus_before", 16'(ioFifoData), 16'h77);
    @(posedge iClk);
    #1;
    iRst = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    chk("rstmid_bus", 16'(ioFifoData), 16'hFF);
    chk("rstmid_rxf", 16'(oRxF_n), 16'h1);
    chk("rstmid_txe", 16'(oTxE_n), 16'h1);
    chk("rstmid_dnlvl", 16'(oDownLevel), 16'd0);
    chk("rstmid_uplvl", 16'(oUpLevel), 16'd0);
    chk("rstmid_upvalid", 16'(oUpValid), 16'h0);
    chk("rstmid_dnrdy", 16'(oDownReady), 16'h1);
    chk("rstmid_err", 16'(oProtoErr), 16'h0);
    tick();
    iRst  = 1'b0;
    iRd_n = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
